dmem_arbiter: RTL and testbench

//  Shares the single-port 256x8 data memory between two requesters: port 0 (core load/store) and port 1
//  (loader/debug). Round-robin arbitration, req/ack handshake, drives the memory's address, read/write

---
 rtl/dmem_arb_pkg.sv | 20 ++
 rtl/dmem_arb_rr_pick.sv | 23 ++
 rtl/dmem_arbiter.sv | 126 ++++++++++++
 tb/tb_dmem_arbiter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

  localparam int NPORTS = 2;
  localparam int STAT_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } arb_state_t;

  typedef logic port_id_t;

  // Counters stick at all-ones instead of wrapping to zero.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == '1) ? v : v + STAT_W'(1);
  endfunction

endpackage

// File: rtl/dmem_arb_rr_pick.sv
// Combinational 2-way round-robin picker: a lone request wins outright,
// a tie goes to the port that did not own the memory last.
module dmem_arb_rr_pick
  import dmem_arb_pkg::*;
(
  input  logic [NPORTS-1:0] req,
  input  port_id_t          last_owner,
  output port_id_t          owner,
  output logic              valid
);

  always_comb begin
    valid = |req;
    owner = 1'b0;
    case (req)
      2'b01:   owner = 1'b0;
      2'b10:   owner = 1'b1;
      2'b11:   owner = ~last_owner;
      default: owner = 1'b0;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between two requesters.
// Optional DMEM_ARB_STATS_EN adds saturating grant/conflict counters.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic [1:0]        req,
  input  logic [1:0]        we,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic [1:0]        ack,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_grants0,
  output logic [STAT_W-1:0] stat_grants1,
  output logic [STAT_W-1:0] stat_conflicts
`endif
);

  arb_state_t        state, state_d;
  port_id_t          owner_q, owner_d;
  port_id_t          last_owner, last_owner_d;
  port_id_t          pick_owner;
  logic              pick_valid;
  logic [1:0]        ack_d;
  logic [DATA_W-1:0] rdata_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_d;
  logic              mem_rd_d, mem_wr_d;

  dmem_arb_rr_pick u_pick (
    .req        (req),
    .last_owner (last_owner),
    .owner      (pick_owner),
    .valid      (pick_valid)
  );

  // The memory address/data registers double as the request latch, so
  // requester-side changes after the grant never reach the memory.
  always_comb begin
    state_d      = state;
    owner_d      = owner_q;
    last_owner_d = last_owner;
    ack_d        = '0;
    rdata_d      = rdata;
    mem_addr_d   = mem_addr;
    mem_wdata_d  = mem_wdata;
    mem_rd_d     = 1'b0;
    mem_wr_d     = 1'b0;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          owner_d     = pick_owner;
          mem_addr_d  = pick_owner ? addr1 : addr0;
          mem_wdata_d = pick_owner ? wdata1 : wdata0;
          mem_wr_d    = we[pick_owner];
          mem_rd_d    = ~we[pick_owner];
          state_d     = ACCESS;
        end
      end
      ACCESS: begin
        if (mem_rd) rdata_d = mem_rdata;
        ack_d[owner_q] = 1'b1;
        state_d        = DONE;
      end
      DONE: begin
        last_owner_d = owner_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state      <= IDLE;
      owner_q    <= 1'b0;
      last_owner <= 1'b1;
      ack        <= '0;
      rdata      <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_rd     <= 1'b0;
      mem_wr     <= 1'b0;
    end else begin
      state      <= state_d;
      owner_q    <= owner_d;
      last_owner <= last_owner_d;
      ack        <= ack_d;
      rdata      <= rdata_d;
      mem_addr   <= mem_addr_d;
      mem_wdata  <= mem_wdata_d;
      mem_rd     <= mem_rd_d;
      mem_wr     <= mem_wr_d;
    end
  end

`ifdef DMEM_ARB_STATS_EN
  always_ff @(posedge CLK) begin
    if (reset) begin
      stat_grants0   <= '0;
      stat_grants1   <= '0;
      stat_conflicts <= '0;
    end else begin
      if (state == DONE) begin
        if (owner_q) stat_grants1 <= sat_inc(stat_grants1);
        else         stat_grants0 <= sat_inc(stat_grants0);
      end
      if (state == IDLE && req == 2'b11) stat_conflicts <= sat_inc(stat_conflicts);
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a behavioural 256x8 memory.
module tb_dmem_arbiter;

  logic       CLK = 1'b0;
  logic       reset;
  logic [1:0] req, we, ack;
  logic [7:0] addr0, addr1, wdata0, wdata1, rdata;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic       mem_rd, mem_wr;
`ifdef DMEM_ARB_STATS_EN
  logic [15:0] stat_grants0, stat_grants1, stat_conflicts;
`endif

  int checks = 0;
  int failures = 0;

  dmem_arbiter dut (
    .CLK       (CLK),
    .reset     (reset),
    .req       (req),
    .we        (we),
    .addr0     (addr0),
    .addr1     (addr1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .ack       (ack),
    .rdata     (rdata),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
`ifdef DMEM_ARB_STATS_EN
    ,
    .stat_grants0   (stat_grants0),
    .stat_grants1   (stat_grants1),
    .stat_conflicts (stat_conflicts)
`endif
  );

  always #5 CLK = ~CLK;

  // Memory preloads addr^8'h5A; reads of an idle bus return 8'hEE so stray sampling shows up.
  logic [7:0] mem [256];
  bit mem_init = 1'b0;
  assign mem_rdata = mem_rd ? mem[mem_addr] : 8'hEE;

  always @(posedge CLK) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h5A;
      mem_init <= 1'b1;
    end else if (mem_wr) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    req = 2'b00;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset;
    we = 2'b00; addr0 = 8'h00; addr1 = 8'h00; wdata0 = 8'h00; wdata1 = 8'h00;
    do_reset();
    checks++;
    if ({ack, mem_rd, mem_wr} !== 4'b0000) begin
      failures++; $display("[TB] FAIL reset_strobes got=%b exp=0000", {ack, mem_rd, mem_wr});
    end
    checks++;
    if ({mem_addr, mem_wdata, rdata} !== 24'h0) begin
      failures++; $display("[TB] FAIL reset_data got=%h exp=000000", {mem_addr, mem_wdata, rdata});
    end
  endtask

  task automatic test_write;
    req = 2'b01; we = 2'b01; addr0 = 8'h10; wdata0 = 8'hA5;
    tick();
    checks++;
    if ({ack, mem_rd, mem_wr, mem_addr, mem_wdata} !== {2'b00, 2'b01, 8'h10, 8'hA5}) begin
      failures++; $display("[TB] FAIL write_access got=%h exp=%h",
                           {ack, mem_rd, mem_wr, mem_addr, mem_wdata}, {2'b00, 2'b01, 8'h10, 8'hA5});
    end
    tick();
    checks++;
    if ({ack, mem_rd, mem_wr, rdata} !== {2'b01, 2'b00, 8'h00}) begin
      failures++; $display("[TB] FAIL write_ack got=%h exp=%h", {ack, mem_rd, mem_wr, rdata}, {2'b01, 2'b00, 8'h00});
    end
    req = 2'b00;
    tick();
    checks++;
    if (ack !== 2'b00) begin
      failures++; $display("[TB] FAIL write_ack_pulse got=%b exp=00", ack);
    end
  endtask

  task automatic test_read;
    req = 2'b01; we = 2'b00; addr0 = 8'h10;
    tick();
    checks++;
    if ({mem_rd, mem_wr, mem_addr} !== {2'b10, 8'h10}) begin
      failures++; $display("[TB] FAIL read_access got=%h exp=%h", {mem_rd, mem_wr, mem_addr}, {2'b10, 8'h10});
    end
    tick();
    checks++;
    if ({ack, mem_wr, rdata} !== {2'b01, 1'b0, 8'hA5}) begin
      failures++; $display("[TB] FAIL read_ack got=%h exp=%h", {ack, mem_wr, rdata}, {2'b01, 1'b0, 8'hA5});
    end
    req = 2'b00;
    tick();
  endtask

  task automatic test_round_robin;
    logic [1:0] exp_ack;
    logic [7:0] exp_addr;
    do_reset();
    req = 2'b11; we = 2'b00; addr0 = 8'h20; addr1 = 8'h21;
    for (int k = 0; k < 4; k++) begin
      exp_ack  = (k % 2 == 0) ? 2'b01 : 2'b10;
      exp_addr = (k % 2 == 0) ? 8'h20 : 8'h21;
      tick();
      checks++;
      if ({ack, mem_rd, mem_addr} !== {2'b00, 1'b1, exp_addr}) begin
        failures++; $display("[TB] FAIL rr_access%0d got=%h exp=%h", k, {ack, mem_rd, mem_addr}, {2'b00, 1'b1, exp_addr});
      end
      tick();
      checks++;
      if ({ack, rdata} !== {exp_ack, exp_addr ^ 8'h5A}) begin
        failures++; $display("[TB] FAIL rr_ack%0d got=%h exp=%h", k, {ack, rdata}, {exp_ack, exp_addr ^ 8'h5A});
      end
      tick();
      checks++;
      if (ack !== 2'b00) begin
        failures++; $display("[TB] FAIL rr_gap%0d got=%b exp=00", k, ack);
      end
    end
    req = 2'b00;
    tick();
  endtask

  task automatic test_wrap_latch;
    req = 2'b10; we = 2'b10; addr1 = 8'hFF; wdata1 = 8'h3C;
    tick();
    checks++;
    if ({mem_wr, mem_addr, mem_wdata} !== {1'b1, 8'hFF, 8'h3C}) begin
      failures++; $display("[TB] FAIL wrap_write got=%h exp=%h", {mem_wr, mem_addr, mem_wdata}, {1'b1, 8'hFF, 8'h3C});
    end
    addr1 = 8'h00; wdata1 = 8'h00; we = 2'b00;
    tick();
    checks++;
    if (ack !== 2'b10) begin
      failures++; $display("[TB] FAIL wrap_write_ack got=%b exp=10", ack);
    end
    req = 2'b00;
    tick();
    req = 2'b01; we = 2'b00; addr0 = 8'hFF;
    tick();
    tick();
    checks++;
    if ({ack, rdata} !== {2'b01, 8'h3C}) begin
      failures++; $display("[TB] FAIL wrap_read got=%h exp=%h", {ack, rdata}, {2'b01, 8'h3C});
    end
    req = 2'b00;
    tick();
  endtask

  task automatic test_drop_req;
    req = 2'b01; we = 2'b00; addr0 = 8'h21;
    tick();
    req = 2'b00;
    tick();
    checks++;
    if ({ack, rdata} !== {2'b01, 8'h7B}) begin
      failures++; $display("[TB] FAIL drop_req_ack got=%h exp=%h", {ack, rdata}, {2'b01, 8'h7B});
    end
    tick();
    tick();
    checks++;
    if ({ack, mem_rd, mem_wr} !== 4'b0000) begin
      failures++; $display("[TB] FAIL drop_req_idle got=%b exp=0000", {ack, mem_rd, mem_wr});
    end
  endtask

  task automatic test_reset_mid;
    req = 2'b01; we = 2'b01; addr0 = 8'h30; wdata0 = 8'h77;
    tick();
    checks++;
    if (mem_wr !== 1'b1) begin
      failures++; $display("[TB] FAIL midrst_setup got=%b exp=1", mem_wr);
    end
    reset = 1'b1; req = 2'b00;
    tick();
    checks++;
    if ({ack, mem_rd, mem_wr, mem_addr, mem_wdata, rdata} !== 28'h0) begin
      failures++; $display("[TB] FAIL midrst_clear got=%h exp=0000000", {ack, mem_rd, mem_wr, mem_addr, mem_wdata, rdata});
    end
    tick();
    reset = 1'b0;
    tick();
    checks++;
    if (ack !== 2'b00) begin
      failures++; $display("[TB] FAIL midrst_noack got=%b exp=00", ack);
    end
    req = 2'b10; we = 2'b00; addr1 = 8'h20;
    tick();
    checks++;
    if ({mem_rd, mem_addr} !== {1'b1, 8'h20}) begin
      failures++; $display("[TB] FAIL midrst_idle got=%h exp=%h", {mem_rd, mem_addr}, {1'b1, 8'h20});
    end
    tick();
    req = 2'b00;
    tick();
  endtask

`ifdef DMEM_ARB_STATS_EN
  task automatic do_access(input bit port);
    req = port ? 2'b10 : 2'b01; we = 2'b00;
    tick();
    tick();
    req = 2'b00;
    tick();
  endtask

  task automatic test_stats;
    do_reset();
    req = 2'b11; we = 2'b00; addr0 = 8'h40; addr1 = 8'h41;
    tick(); tick(); tick();
    tick(); tick();
    req = 2'b00;
    tick();
    for (int i = 0; i < 4; i++) do_access(1'b0);
    for (int i = 0; i < 2; i++) do_access(1'b1);
    checks++;
    if ({stat_grants0, stat_grants1, stat_conflicts} !== {16'd5, 16'd3, 16'd2}) begin
      failures++; $display("[TB] FAIL stats got=%0d/%0d/%0d exp=5/3/2", stat_grants0, stat_grants1, stat_conflicts);
    end
  endtask
`endif

  initial begin
    reset = 1'b1; req = 2'b00; we = 2'b00;
    addr0 = 8'h00; addr1 = 8'h00; wdata0 = 8'h00; wdata1 = 8'h00;
    test_reset();
    test_write();
    test_read();
    test_round_robin();
    test_wrap_latch();
    test_drop_req();
    test_reset_mid();
`ifdef DMEM_ARB_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout got=running exp=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
